// File: rtl/xeng_vacc_if.sv
// Stream bundle for the vector accumulator: tap-chain words in, integrated slot vectors out.
// The master drives sync/valid/acc words and the slave returns dout/dout_valid/dout_addr/sync_out/armed.
interface xeng_vacc_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 22,
    parameter int AW    = 10
);
    logic                 sync_in;
    logic [8*IN_W-1:0]    acc_in;
    logic                 valid_in;
    logic [8*OUT_W-1:0]   dout;
    logic                 dout_valid;
    logic [AW-1:0]        dout_addr;
    logic                 sync_out;
    logic                 armed;

    modport master (
        output sync_in, acc_in, valid_in,
        input  dout, dout_valid, dout_addr, sync_out, armed
    );

    modport slave (
        input  sync_in, acc_in, valid_in,
        output dout, dout_valid, dout_addr, sync_out, armed
    );
endinterface

// File: rtl/xeng_vacc.sv
// Long-term vector accumulator: sums 2^VACC_LEN_BITS dump windows per slot in RAM, 2-cycle latency.
// No backpressure; ce=0 freezes every register and suppresses RAM writes.
module xeng_vacc #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int VEC_LEN             = 544,
    parameter int VACC_LEN_BITS       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    xeng_vacc_if.slave bus
);
    localparam int IN_W  = 2*BITWIDTH + 1 + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS;
    localparam int OUT_W = IN_W + VACC_LEN_BITS;
    localparam int AW    = $clog2(VEC_LEN);

    logic                     armed_q, armed_d;
    logic [AW-1:0]            slot_q, slot_d, cur_slot;
    logic [VACC_LEN_BITS-1:0] dump_q, dump_d, cur_dump;
    logic                     acc_vld;

    logic                     s1_vld_q, s1_first_q, s1_last_q;
    logic [8*IN_W-1:0]        s1_dat_q;
    logic [AW-1:0]            s1_slot_q;
    logic [8*OUT_W-1:0]       rd_q;
    logic [8*OUT_W-1:0]       sum;
    logic [OUT_W-1:0]         ext, old;

    logic                     sync_d1_q, sync_out_q;
    logic                     dout_vld_q;
    logic [8*OUT_W-1:0]       dout_q;
    logic [AW-1:0]            dout_addr_q;

    logic [8*OUT_W-1:0]       ram_q [VEC_LEN];

    // A sync in the same cycle as a word makes that word slot 0 of dump 0.
    always_comb begin
        acc_vld  = bus.valid_in & ce & (armed_q | bus.sync_in);
        cur_slot = bus.sync_in ? '0 : slot_q;
        cur_dump = bus.sync_in ? '0 : dump_q;
        armed_d  = armed_q | bus.sync_in;
        slot_d   = cur_slot;
        dump_d   = cur_dump;
        if (acc_vld) begin
            if (cur_slot == AW'(VEC_LEN-1)) begin
                slot_d = '0;
                dump_d = cur_dump + VACC_LEN_BITS'(1);
            end else begin
                slot_d = cur_slot + AW'(1);
            end
        end
    end

    // Per-component sign extension and add; components never carry into each other.
    always_comb begin
        sum = '0;
        ext = '0;
        old = '0;
        for (int k = 0; k < 8; k++) begin
            ext = {{VACC_LEN_BITS{s1_dat_q[k*IN_W+IN_W-1]}}, s1_dat_q[k*IN_W +: IN_W]};
            old = s1_first_q ? '0 : rd_q[k*OUT_W +: OUT_W];
            sum[k*OUT_W +: OUT_W] = old + ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            slot_q      <= '0;
            dump_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_dat_q    <= '0;
            s1_slot_q   <= '0;
            sync_d1_q   <= 1'b0;
            sync_out_q  <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_q      <= '0;
            dout_addr_q <= '0;
        end else if (ce) begin
            armed_q    <= armed_d;
            slot_q     <= slot_d;
            dump_q     <= dump_d;
            s1_vld_q   <= acc_vld;
            s1_first_q <= (cur_dump == '0);
            s1_last_q  <= &cur_dump;
            s1_dat_q   <= bus.acc_in;
            s1_slot_q  <= cur_slot;
            sync_d1_q  <= bus.sync_in;
            sync_out_q <= sync_d1_q;
            dout_vld_q <= s1_vld_q & s1_last_q;
            if (s1_vld_q & s1_last_q) begin
                dout_q      <= sum;
                dout_addr_q <= s1_slot_q;
            end
        end
    end

    // VEC_LEN >= 4 keeps a slot's reread well after its write-back, so no bypass path.
    always_ff @(posedge clk) begin
        if (ce) begin
            rd_q <= ram_q[cur_slot];
            if (s1_vld_q) begin
                ram_q[s1_slot_q] <= sum;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_vld_q;
    assign bus.dout_addr  = dout_addr_q;
    assign bus.sync_out   = sync_out_q;
    assign bus.armed      = armed_q;
endmodule

// File: tb/tb_xeng_vacc.sv
// Scoreboarded bench for xeng_vacc: word-level reference model feeds an expect queue, a monitor pops on dout_valid.
module tb_xeng_vacc;
    localparam int VEC_LEN = 4;
    localparam int VLB     = 2;
    localparam int NDUMP   = 4;
    localparam int IN_W    = 18;
    localparam int OUT_W   = 20;
    localparam int AW      = 2;

    typedef struct packed {
        logic [8*OUT_W-1:0] dat;
        logic [AW-1:0]      addr;
        logic [31:0]        cyc;
        logic               tchk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    always #5 clk = ~clk;

    xeng_vacc_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();

    xeng_vacc #(.VEC_LEN(VEC_LEN), .VACC_LEN_BITS(VLB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus)
    );

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     n_vhigh = 0;
    int     v0;
    logic   last_ce = 1'b0;
    bit     tchk_en = 1'b1;
    bit     m_armed = 1'b0;
    int     m_slot = 0;
    int     m_dump = 0;
    longint m_acc[VEC_LEN][8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain per-slot integer sums, one window counted per full pass over the slots.
    task automatic model(input bit s, input bit v, input bit c, input logic [8*IN_W-1:0] w);
        longint x;
        exp_t   e;
        if (!c) return;
        if (s) begin
            m_armed = 1'b1;
            m_slot  = 0;
            m_dump  = 0;
        end
        if (v && m_armed) begin
            for (int k = 0; k < 8; k++) begin
                x = longint'($signed(w[k*IN_W +: IN_W]));
                if (m_dump == 0) m_acc[m_slot][k] = x;
                else             m_acc[m_slot][k] = m_acc[m_slot][k] + x;
            end
            if (m_dump == NDUMP-1) begin
                e = '0;
                for (int k = 0; k < 8; k++) e.dat[k*OUT_W +: OUT_W] = m_acc[m_slot][k][OUT_W-1:0];
                e.addr = AW'(m_slot);
                e.cyc  = 32'(cyc + 2);
                e.tchk = tchk_en;
                q.push_back(e);
            end
            m_slot++;
            if (m_slot == VEC_LEN) begin
                m_slot = 0;
                m_dump = (m_dump + 1) % NDUMP;
            end
        end
    endtask

    task automatic drive(input bit s, input bit v, input bit c, input logic [8*IN_W-1:0] w);
        @(posedge clk);
        #1;
        bus.sync_in  = s;
        bus.valid_in = v;
        bus.acc_in   = w;
        ce           = c;
        model(s, v, c, w);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1, '0);
    endtask

    function automatic logic [8*IN_W-1:0] fill(input int val);
        logic [8*IN_W-1:0] f;
        for (int k = 0; k < 8; k++) f[k*IN_W +: IN_W] = IN_W'(val);
        return f;
    endfunction

    function automatic logic [8*IN_W-1:0] kpat(input int s);
        logic [8*IN_W-1:0] f;
        for (int k = 0; k < 8; k++) f[k*IN_W +: IN_W] = IN_W'(k + s);
        return f;
    endfunction

    function automatic logic [8*IN_W-1:0] rnd();
        logic [8*IN_W-1:0] f;
        for (int k = 0; k < 8; k++) f[k*IN_W +: IN_W] = IN_W'($urandom);
        return f;
    endfunction

    always @(posedge clk) begin
        cyc     = cyc + 1;
        last_ce = ce;
    end

    // A fresh output is one seen after an edge where ce was high; held values under stall are not re-popped.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dout_valid) n_vhigh++;
            if (bus.dout_valid && last_ce) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: dout_valid=1 addr=%0d dout=%h with nothing expected",
                             bus.dout_addr, bus.dout);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("dout_addr", 256'(bus.dout_addr), 256'(e.addr));
                    chk("dout", 256'(bus.dout), 256'(e.dat));
                    if (e.tchk) chk("latency_cycle", 256'(cyc), 256'(e.cyc));
                end
            end
        end
    end

    initial begin
        bus.sync_in  = 1'b0;
        bus.valid_in = 1'b0;
        bus.acc_in   = '0;
        ce           = 1'b1;
        rst_n        = 1'b0;
        #12;
        chk("rst_dout", 256'(bus.dout), 256'(0));
        chk("rst_dout_valid", 256'(bus.dout_valid), 256'(0));
        chk("rst_dout_addr", 256'(bus.dout_addr), 256'(0));
        chk("rst_sync_out", 256'(bus.sync_out), 256'(0));
        chk("rst_armed", 256'(bus.armed), 256'(0));
        #10 rst_n = 1'b1;

        v0 = n_vhigh;
        repeat (16) drive(1'b0, 1'b1, 1'b1, fill(1));
        idle(4);
        chk("nosync_vld_cycles", 256'(n_vhigh - v0), 256'(0));
        chk("nosync_armed", 256'(bus.armed), 256'(0));

        v0 = n_vhigh;
        for (int i = 0; i < 16; i++) begin
            drive(i == 0, 1'b1, 1'b1, fill(1));
            if (i == 1) chk("sync_out_d1", 256'(bus.sync_out), 256'(0));
            if (i == 2) chk("sync_out_d2", 256'(bus.sync_out), 256'(1));
        end
        idle(4);
        chk("ones_vld_cycles", 256'(n_vhigh - v0), 256'(4));
        chk("armed_after_sync", 256'(bus.armed), 256'(1));

        for (int i = 0; i < 16; i++) drive(i == 0, 1'b1, 1'b1, fill(-(1 << (IN_W-1))));
        idle(4);
        for (int i = 0; i < 16; i++) drive(i == 0, 1'b1, 1'b1, kpat(i % VEC_LEN));
        idle(4);

        drive(1'b1, 1'b1, 1'b1, rnd());
        repeat (5) drive(1'b0, 1'b1, 1'b1, rnd());
        v0 = n_vhigh;
        for (int i = 0; i < 16; i++) drive(i == 0, 1'b1, 1'b1, fill(1));
        idle(4);
        chk("midsync_vld_cycles", 256'(n_vhigh - v0), 256'(4));

        tchk_en = 1'b0;
        v0 = n_vhigh;
        for (int i = 0; i < 14; i++) drive(i == 0, 1'b1, 1'b1, fill(1));
        repeat (3) drive(1'b0, 1'b1, 1'b0, rnd());
        repeat (2) drive(1'b0, 1'b1, 1'b1, fill(1));
        idle(4);
        chk("stall_vld_cycles", 256'(n_vhigh - v0), 256'(7));
        tchk_en = 1'b1;

        for (int i = 0; i < 15; i++) drive(i == 0, 1'b1, 1'b1, fill(1));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_dout", 256'(bus.dout), 256'(0));
        chk("midrst_dout_valid", 256'(bus.dout_valid), 256'(0));
        chk("midrst_dout_addr", 256'(bus.dout_addr), 256'(0));
        chk("midrst_armed", 256'(bus.armed), 256'(0));
        q.delete();
        m_armed = 1'b0;
        m_slot  = 0;
        m_dump  = 0;
        bus.valid_in = 1'b0;
        bus.sync_in  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_vhigh;
        repeat (16) drive(1'b0, 1'b1, 1'b1, fill(1));
        idle(4);
        chk("postrst_vld_cycles", 256'(n_vhigh - v0), 256'(0));
        chk("postrst_armed", 256'(bus.armed), 256'(0));

        tchk_en = 1'b0;
        drive(1'b1, 1'b1, 1'b1, rnd());
        repeat (400) drive($urandom % 50 == 0, $urandom % 4 != 0, $urandom % 6 != 0, rnd());
        idle(6);
        chk("queue_drained", 256'(q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
